pipelined_shifter: RTL and testbench



---
 rtl/pipelined_shifter.sv | 161 ++++++++++++++++
 tb/tb_pipelined_shifter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_shifter: PIPE-stage barrel shifter (LSL/LSR/ASR/ROR/ROL),        |
// | valid/ready handshake with global stall, carry and zero flags.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipelined_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [2:0]       shift_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic             carry_out,
  output logic             zero_out
);

  localparam int BASE  = AMT_W / PIPE;
  localparam int EXTRA = AMT_W % PIPE;

  logic w_stall;
  logic w_accept;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;

  // One layer of shift by sh; carry is the last bit to leave in that layer,
  // so chaining layers leaves the carry of the complete shift.
  function automatic logic [WIDTH:0] f_layer(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       ctl,
                                             input int               sh);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] t;
    logic             c;
    r = d;
    t = d;
    c = 1'b0;
    casez (ctl)
      3'b0??: begin
        r = d << sh;
        t = d >> (WIDTH - sh);
        c = t[0];
      end
      3'b100: begin
        r = d >> sh;
        t = d >> (sh - 1);
        c = t[0];
      end
      3'b101: begin
        r = $signed(d) >>> sh;
        t = d >> (sh - 1);
        c = t[0];
      end
      3'b110: begin
        r = (d >> sh) | (d << (WIDTH - sh));
        c = r[WIDTH-1];
      end
      default: begin
        r = (d << sh) | (d >> (WIDTH - sh));
        c = r[0];
      end
    endcase
    return {c, r};
  endfunction

  for (genvar g = 0; g < PIPE; g++) begin : g_stage
    // Earlier groups take the extra layers.
    localparam int LO = g * BASE + ((g < EXTRA) ? g : EXTRA);
    localparam int N  = BASE + ((g < EXTRA) ? 1 : 0);

    logic                w_v_in;
    logic [WIDTH-1:0]    w_d_in;
    logic [2:0]          w_ctl_in;
    logic [AMT_W-LO-1:0] w_amt_in;
    logic                w_c_in;
    logic [WIDTH-1:0]    w_d;
    logic                w_c;

    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic                r_carry;

    if (g == 0) begin : g_first
      assign w_v_in   = w_accept;
      assign w_d_in   = shift_in;
      assign w_ctl_in = shift_ctl;
      assign w_amt_in = shift_amt;
      assign w_c_in   = 1'b0;
    end else begin : g_next
      assign w_v_in   = g_stage[g-1].r_valid;
      assign w_d_in   = g_stage[g-1].r_data;
      assign w_ctl_in = g_stage[g-1].g_fwd.r_ctl;
      assign w_amt_in = g_stage[g-1].g_fwd.r_amt;
      assign w_c_in   = g_stage[g-1].r_carry;
    end

    always_comb begin
      w_d = w_d_in;
      w_c = w_c_in;
      for (int k = 0; k < N; k++) begin
        if (w_amt_in[k]) {w_c, w_d} = f_layer(w_d, w_ctl_in, 1 << (LO + k));
      end
    end

    // Data holds across bubbles so the outputs keep their last value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_carry <= 1'b0;
      end else if (!w_stall) begin
        r_valid <= w_v_in;
        if (w_v_in) begin
          r_data  <= w_d;
          r_carry <= w_c;
        end
      end
    end

    if (g < PIPE - 1) begin : g_fwd
      logic [2:0]            r_ctl;
      logic [AMT_W-LO-N-1:0] r_amt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ctl <= 3'b000;
          r_amt <= '0;
        end else if (!w_stall && w_v_in) begin
          r_ctl <= w_ctl_in;
          r_amt <= w_amt_in[AMT_W-LO-1:N];
        end
      end
    end else begin : g_last
      logic r_zero;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_zero <= 1'b0;
        end else if (!w_stall && w_v_in) begin
          r_zero <= (w_d == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[PIPE-1].r_valid;
  assign shift_out = g_stage[PIPE-1].r_data;
  assign carry_out = g_stage[PIPE-1].r_carry;
  assign zero_out  = g_stage[PIPE-1].g_last.r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_shifter: directed and random checks of pipelined_shifter.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipelined_shifter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] shift_in;
  logic [3:0]  shift_amt;
  logic [2:0]  shift_ctl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] shift_out;
  logic        carry_out;
  logic        zero_out;

  int n_chk;
  int n_fail;

  logic [16:0] sb[$];
  logic        prev_stall;
  logic [17:0] prev_out;

  pipelined_shifter #(
    .WIDTH(16),
    .AMT_W(4),
    .PIPE (2)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .shift_in (shift_in),
    .shift_amt(shift_amt),
    .shift_ctl(shift_ctl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .shift_out(shift_out),
    .carry_out(carry_out),
    .zero_out (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} from whole-word arithmetic on a double-width word.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] a,
                                        input logic [2:0] c);
    logic [31:0] w;
    logic [15:0] r;
    logic        co;
    int          n;
    n  = int'(a);
    w  = 32'h0;
    r  = d;
    co = 1'b0;
    if (n != 0) begin
      casez (c)
        3'b0??: begin w = {16'h0, d} << n; r = w[15:0];  co = w[16]; end
        3'b100: begin w = {d, 16'h0} >> n; r = w[31:16]; co = w[15]; end
        3'b101: begin w = $signed({d, 16'h0}) >>> n; r = w[31:16]; co = w[15]; end
        3'b110: begin w = {d, d} >> n; r = w[15:0];  co = r[15]; end
        default: begin w = {d, d} << n; r = w[31:16]; co = r[0]; end
      endcase
    end
    return {co, r};
  endfunction

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset) begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_out", 32'({carry_out, zero_out, shift_out}), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(shift_out), 32'(e[15:0]));
          chk("carry", 32'(carry_out), 32'(e[16]));
          chk("zero", 32'(zero_out), 32'(e[15:0] == 16'h0));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(shift_in, shift_amt, shift_ctl));
      prev_stall = out_valid && !out_ready;
      prev_out   = {carry_out, zero_out, shift_out};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic directed(input string tag, input logic [15:0] d, input logic [3:0] a,
                          input logic [2:0] c, input logic [15:0] ed, input logic ec,
                          input logic ez);
    int lat;
    in_valid  = 1'b1;
    shift_in  = d;
    shift_amt = a;
    shift_ctl = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_data"}, 32'(shift_out), 32'(ed));
    chk({tag, "_carry"}, 32'(carry_out), 32'(ec));
    chk({tag, "_zero"}, 32'(zero_out), 32'(ez));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0]  mask;
    logic [15:0] saved;
    int          idx;
    int          nacc;
    int          t;
    logic        acc;

    n_chk      = 0;
    n_fail     = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    shift_in   = 16'h0;
    shift_amt  = 4'h0;
    shift_ctl  = 3'b000;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(shift_out), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_zero", 32'(zero_out), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    directed("lsl", 16'h3C3C, 4'd3, 3'b000, 16'hE1E0, 1'b1, 1'b0);
    directed("asr", 16'h8000, 4'd3, 3'b101, 16'hF000, 1'b0, 1'b0);
    directed("lsr", 16'h00FF, 4'd8, 3'b100, 16'h0000, 1'b1, 1'b1);
    directed("ror", 16'h0001, 4'd1, 3'b110, 16'h8000, 1'b1, 1'b0);
    directed("rol", 16'h8001, 4'd4, 3'b111, 16'h0018, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      directed("amt0", 16'hA5A5, 4'd0, 3'(c), 16'hA5A5, 1'b0, 1'b0);
    end

    // Back-to-back stream.
    mask = 8'h0;
    for (int k = 1; k <= 8; k++) begin
      in_valid  = (k <= 5);
      shift_in  = 16'(16'h1234 * k);
      shift_amt = 4'(k);
      shift_ctl = 3'(k);
      if (k <= 5) chk("stream_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      mask[k-1] = out_valid;
    end
    chk("stream_valid_pattern", 32'(mask), 32'h3E);
    drain("stream_drain");

    // Stall with 4 operands offered.
    out_ready = 1'b0;
    idx  = 0;
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid  = (idx < 4);
      shift_in  = 16'(16'h1111 * (idx + 1));
      shift_amt = 4'(idx + 1);
      shift_ctl = 3'(idx + 3);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) chk("stall_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        nacc++;
      end
    end
    chk("stall_accepted", 32'(nacc), 32'd2);
    chk("stall_valid", 32'(out_valid), 32'd1);
    saved = shift_out;
    repeat (3) @(posedge clk);
    #1 chk("stall_stable", 32'(shift_out), 32'(saved));
    out_ready = 1'b1;
    t = 0;
    while (idx < 4 && t < 20) begin
      in_valid  = 1'b1;
      shift_in  = 16'(16'h1111 * (idx + 1));
      shift_amt = 4'(idx + 1);
      shift_ctl = 3'(idx + 3);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      t++;
    end
    in_valid = 1'b0;
    chk("stall_all_offered", 32'(idx), 32'd4);
    drain("stall_drain");

    // Asynchronous reset with two operands in flight.
    in_valid  = 1'b1;
    shift_in  = 16'h8001;
    shift_amt = 4'd1;
    shift_ctl = 3'b000;
    @(posedge clk); #1;
    shift_in  = 16'h00F0;
    shift_amt = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    sb.delete();
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(shift_out), 32'd0);
    chk("arst_carry", 32'(carry_out), 32'd0);
    chk("arst_zero", 32'(zero_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_stale", 32'(out_valid), 32'd0);
    end
    directed("post_rst", 16'h00F0, 4'd4, 3'b110, 16'h000F, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      shift_in  = 16'($urandom);
      shift_amt = 4'($urandom_range(0, 15));
      shift_ctl = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
